// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: column strobe, debounce, held/release tracking.
// Define KEYPAD_SCAN_REPEAT_EN to re-pulse valid every REPEAT_CYC clocks while held.
module keypad_scanner #(
    parameter int KEY_ROW      = 4,
    parameter int KEY_COL      = 4,
    parameter int SCAN_DIV     = 4,
    parameter int DEBOUNCE_CYC = 8,
    parameter int REPEAT_CYC   = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [KEY_ROW-1:0] row_in,
    output logic [KEY_COL-1:0] col_drv,
    output logic [KEY_ROW-1:0] row,
    output logic [KEY_COL-1:0] col,
    output logic               key_in,
    output logic               valid
);

    localparam int DW = $clog2(SCAN_DIV + 1);
    localparam int CW = $clog2(DEBOUNCE_CYC + 1);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

    state_t             state;
    logic [KEY_ROW-1:0] sync1;
    logic [KEY_ROW-1:0] rs;
    logic [KEY_ROW-1:0] lmask;
    logic [KEY_ROW-1:0] lrow;
    logic [KEY_ROW-1:0] low;
    logic [KEY_COL-1:0] ccol;
    logic [KEY_COL-1:0] ncol;
    logic [DW-1:0]      dwell;
    logic [CW-1:0]      cnt;
    logic               lbit;

`ifdef KEYPAD_SCAN_REPEAT_EN
    localparam int RW = $clog2(REPEAT_CYC + 1);
    logic [RW-1:0]      rep;
`endif

    // lowest set row wins when several rows are active
    always_comb begin
        low = '0;
        for (int i = KEY_ROW - 1; i >= 0; i--) begin
            if (rs[i]) low = KEY_ROW'(i);
        end
    end

    assign lbit = |(rs & lmask);
    assign ncol = (ccol == KEY_COL'(KEY_COL - 1)) ? '0 : ccol + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1   <= '0;
            rs      <= '0;
            state   <= SCAN;
            col_drv <= KEY_COL'(1);
            ccol    <= '0;
            row     <= '0;
            col     <= '0;
            key_in  <= 1'b0;
            valid   <= 1'b0;
            lmask   <= '0;
            lrow    <= '0;
            dwell   <= '0;
            cnt     <= '0;
`ifdef KEYPAD_SCAN_REPEAT_EN
            rep     <= '0;
`endif
        end else begin
            sync1 <= row_in;
            rs    <= sync1;
            valid <= 1'b0;
            unique case (state)
                SCAN: begin
                    if (dwell == DW'(SCAN_DIV - 1)) begin
                        dwell <= '0;
                        if (|rs) begin
                            lmask <= rs & (~rs + 1'b1);
                            lrow  <= low;
                            cnt   <= '0;
                            state <= DEBOUNCE;
                        end else begin
                            col_drv <= {col_drv[KEY_COL-2:0], col_drv[KEY_COL-1]};
                            ccol    <= ncol;
                        end
                    end else begin
                        dwell <= dwell + 1'b1;
                    end
                end
                DEBOUNCE: begin
                    if (!lbit) begin
                        dwell <= '0;
                        state <= SCAN;
                    end else if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
                        row    <= lrow;
                        col    <= ccol;
                        key_in <= 1'b1;
                        valid  <= 1'b1;
                        state  <= HELD;
`ifdef KEYPAD_SCAN_REPEAT_EN
                        rep    <= '0;
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HELD: begin
                    if (!lbit) begin
                        cnt   <= '0;
                        state <= RELEASE;
                    end else begin
`ifdef KEYPAD_SCAN_REPEAT_EN
                        if (rep == RW'(REPEAT_CYC - 1)) begin
                            rep   <= '0;
                            valid <= 1'b1;
                        end else begin
                            rep <= rep + 1'b1;
                        end
`endif
                    end
                end
                RELEASE: begin
                    if (lbit) begin
                        state <= HELD;
`ifdef KEYPAD_SCAN_REPEAT_EN
                        rep   <= '0;
`endif
                    end else if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
                        key_in  <= 1'b0;
                        dwell   <= '0;
                        col_drv <= {col_drv[KEY_COL-2:0], col_drv[KEY_COL-1]};
                        ccol    <= ncol;
                        state   <= SCAN;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= SCAN;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner against a behavioural key model.
// Honours KEYPAD_SCAN_REPEAT_EN for the auto-repeat expectations.
module tb_keypad_scanner;

    localparam int NR  = 4;
    localparam int NC  = 4;
    localparam int DIV = 4;
    localparam int DEB = 8;
    localparam int REP = 64;
`ifdef KEYPAD_SCAN_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    localparam int M_SCAN = 0;
    localparam int M_DEB  = 1;
    localparam int M_HELD = 2;
    localparam int M_REL  = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NR-1:0] row_in = '0;
    logic [NC-1:0] col_drv;
    logic [NR-1:0] row;
    logic [NC-1:0] col;
    logic          key_in;
    logic          valid;

    keypad_scanner #(
        .KEY_ROW(NR), .KEY_COL(NC), .SCAN_DIV(DIV),
        .DEBOUNCE_CYC(DEB), .REPEAT_CYC(REP)
    ) dut (
        .clk(clk), .rst(rst), .row_in(row_in), .col_drv(col_drv),
        .row(row), .col(col), .key_in(key_in), .valid(valid)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int vcount = 0;

    // model state: phase, scanned column, dwell position, latched row, run lengths
    int m_phase = M_SCAN;
    int m_col = 0;
    int m_dwell = 0;
    int m_lrow = 0;
    int m_cnt = 0;
    int m_rep = 0;
    int e_row = 0;
    int e_col = 0;
    int e_key = 0;
    int e_valid = 0;
    logic [NR-1:0] s1 = '0;
    logic [NR-1:0] s2 = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        checks++;
        failures++;
        $error("FAIL %s observed=timeout expected=event", tag);
    endtask

    function automatic int lowest(input logic [NR-1:0] v);
        for (int i = 0; i < NR; i++) if (v[i]) return i;
        return 0;
    endfunction

    task automatic model_edge(input logic [NR-1:0] rin, input bit r);
        bit hb;
        if (r) begin
            m_phase = M_SCAN; m_col = 0; m_dwell = 0; m_lrow = 0;
            m_cnt = 0; m_rep = 0; e_row = 0; e_col = 0;
            e_key = 0; e_valid = 0; s1 = '0; s2 = '0;
            return;
        end
        hb = s2[m_lrow];
        e_valid = 0;
        case (m_phase)
            M_SCAN: begin
                if (m_dwell == DIV - 1) begin
                    m_dwell = 0;
                    if (s2 != 0) begin
                        m_lrow = lowest(s2); m_cnt = 0; m_phase = M_DEB;
                    end else m_col = (m_col + 1) % NC;
                end else m_dwell++;
            end
            M_DEB: begin
                if (!hb) begin
                    m_phase = M_SCAN; m_dwell = 0;
                end else begin
                    m_cnt++;
                    if (m_cnt == DEB) begin
                        m_phase = M_HELD; e_row = m_lrow; e_col = m_col;
                        e_key = 1; e_valid = 1; m_rep = 0;
                    end
                end
            end
            M_HELD: begin
                if (!hb) begin
                    m_phase = M_REL; m_cnt = 0;
                end else if (REP_EN) begin
                    m_rep++;
                    if (m_rep == REP) begin e_valid = 1; m_rep = 0; end
                end
            end
            default: begin
                if (hb) begin
                    m_phase = M_HELD; m_rep = 0;
                end else begin
                    m_cnt++;
                    if (m_cnt == DEB) begin
                        m_phase = M_SCAN; e_key = 0; m_dwell = 0;
                        m_col = (m_col + 1) % NC;
                    end
                end
            end
        endcase
        s2 = s1;
        s1 = rin;
    endtask

    task automatic step(input logic [NR-1:0] rin, input bit r);
        @(negedge clk);
        row_in = rin;
        rst = r;
        @(posedge clk);
        model_edge(rin, r);
        #1;
        chk("col_drv", 32'(col_drv), 32'(1 << m_col));
        chk("row", 32'(row), 32'(e_row));
        chk("col", 32'(col), 32'(e_col));
        chk("key_in", 32'(key_in), 32'(e_key));
        chk("valid", 32'(valid), 32'(e_valid));
        if (valid) vcount++;
    endtask

    task automatic wait_col(input int c);
        bit ok = 0;
        for (int i = 0; i < 60; i++) begin
            if (m_phase == M_SCAN && m_col == c && m_dwell == 0) begin ok = 1; break; end
            step('0, 0);
        end
        if (!ok) timeout("wait_col");
    endtask

    task automatic press(input logic [NR-1:0] rin);
        bit ok = 0;
        for (int i = 0; i < 40; i++) begin
            step(rin, 0);
            if (e_key == 1 && e_valid == 1) begin ok = 1; break; end
        end
        if (!ok) timeout("press");
    endtask

    task automatic release_all();
        bit ok = 0;
        for (int i = 0; i < 40; i++) begin
            step('0, 0);
            if (m_phase == M_SCAN) begin ok = 1; break; end
        end
        if (!ok) timeout("release");
    endtask

    initial begin
        int v0;
        int q[$];
        bit ok;

        // reset and idle scan sequence
        step('0, 1);
        chk("rst_col_drv", 32'(col_drv), 32'h1);
        chk("rst_key_in", 32'(key_in), 32'h0);
        v0 = vcount;
        for (int k = 1; k <= 20; k++) begin
            step('0, 0);
            chk("scan_seq", 32'(col_drv), 32'(1 << ((k / DIV) % NC)));
        end
        chk("idle_no_valid", 32'(vcount - v0), 32'h0);

        // row 2 at column 1
        wait_col(1);
        v0 = vcount;
        press(4'b0100);
        chk("r2_row", 32'(row), 32'd2);
        chk("r2_col", 32'(col), 32'd1);
        chk("r2_drv", 32'(col_drv), 32'b0010);
        chk("r2_key", 32'(key_in), 32'd1);
        for (int i = 0; i < 10; i++) step(4'b0100, 0);
        chk("r2_one_valid", 32'(vcount - v0), 32'd1);
        release_all();
        chk("r2_hold_row", 32'(row), 32'd2);

        // short glitch on row 0 at column 3
        wait_col(3);
        v0 = vcount;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            step(4'b0001, 0);
            if (m_phase == M_DEB) begin ok = 1; break; end
        end
        if (!ok) timeout("glitch_detect");
        step(4'b0001, 0);
        step(4'b0001, 0);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            step('0, 0);
            if (m_phase == M_SCAN) begin ok = 1; break; end
        end
        if (!ok) timeout("glitch_return");
        chk("glitch_drv", 32'(col_drv), 32'b1000);
        chk("glitch_key", 32'(key_in), 32'd0);
        chk("glitch_no_valid", 32'(vcount - v0), 32'd0);

        // rows 1 and 3 at column 2, then bouncy release
        wait_col(2);
        press(4'b1010);
        chk("multi_row", 32'(row), 32'd1);
        chk("multi_col", 32'(col), 32'd2);
        for (int i = 0; i < 5; i++) step(4'b1010, 0);
        v0 = vcount;
        step(4'b0000, 0);
        step(4'b1010, 0);
        step(4'b0000, 0);
        step(4'b1010, 0);
        for (int i = 0; i < 3; i++) step(4'b0000, 0);
        chk("bounce_key", 32'(key_in), 32'd1);
        release_all();
        chk("bounce_no_valid", 32'(vcount - v0), 32'd0);
        chk("rel_key", 32'(key_in), 32'd0);
        chk("rel_drv", 32'(col_drv), 32'b1000);

        // reset while held
        wait_col(1);
        press(4'b0100);
        step(4'b0100, 0);
        step(4'b0100, 1);
        chk("rh_drv", 32'(col_drv), 32'h1);
        chk("rh_row", 32'(row), 32'h0);
        chk("rh_col", 32'(col), 32'h0);
        chk("rh_key", 32'(key_in), 32'h0);
        chk("rh_valid", 32'(valid), 32'h0);

        // long hold: auto-repeat pulses at +64, +128, +192 when enabled
        wait_col(0);
        press(4'b1000);
        q.delete();
        for (int i = 1; i <= 200; i++) begin
            step(4'b1000, 0);
            if (valid) q.push_back(i);
        end
        chk("rep_count", 32'(q.size()), REP_EN ? 32'd3 : 32'd0);
        for (int i = 0; i < q.size(); i++)
            chk("rep_offset", 32'(q[i]), 32'(REP * (i + 1)));
        release_all();

        // randomized key activity with occasional reset
        for (int n = 0; n < 60; n++) begin
            logic [NR-1:0] pat;
            int len;
            pat = ($urandom_range(0, 1) == 1) ? NR'($urandom_range(0, 15)) : '0;
            len = $urandom_range(1, 25);
            for (int i = 0; i < len; i++)
                step(pat, $urandom_range(0, 99) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
